// File: rtl/pixel_window_fetch.sv
// Cross-neighbourhood fetcher: reads C,N,S,W,E bytes of one pixel, one read at a time,
// and presents them as the 40-bit cuarenta word. Off-image taps reuse the centre byte.
module pixel_window_fetch #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       fila,
  input  logic [15:0]       col,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [39:0]       cuarenta
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | present read for tap k (strobe suppressed if tap is off-image)
  // CAPT  | capture tap k byte into shadow; last tap publishes cuarenta
  // DONE  | one-cycle done pulse, err valid
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  localparam logic [15:0] IMG_W16 = 16'(IMG_W);
  localparam logic [15:0] IMG_H16 = 16'(IMG_H);

  state_t            state, state_nxt;
  logic [2:0]        tap;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [15:0]       row_q, col_q;
  logic              err_q;
  logic [7:0]        shadow [5];

  logic [15:0]       tap_row, tap_col;
  logic              tap_ok;
  logic [ADDR_W-1:0] tap_addr;
  logic [7:0]        cap_byte;
  logic              req_bad;

  assign req_bad = (fila >= IMG_H16) || (col >= IMG_W16);

  // Tap k = 0..4 selects C,N,S,W,E; tap_ok is low when that neighbour lies outside the image.
  always_comb begin
    tap_row = row_q;
    tap_col = col_q;
    tap_ok  = 1'b1;
    case (tap)
      3'd1: begin
        tap_row = row_q - 16'd1;
        tap_ok  = (row_q != 16'd0);
      end
      3'd2: begin
        tap_row = row_q + 16'd1;
        tap_ok  = (row_q != IMG_H16 - 16'd1);
      end
      3'd3: begin
        tap_col = col_q - 16'd1;
        tap_ok  = (col_q != 16'd0);
      end
      3'd4: begin
        tap_col = col_q + 16'd1;
        tap_ok  = (col_q != IMG_W16 - 16'd1);
      end
      default: ;
    endcase
  end

  assign tap_addr = base_q + ADDR_W'(tap_row) * ADDR_W'(IMG_W) + ADDR_W'(tap_col);
  assign cap_byte = tap_ok ? mem_data : shadow[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:  if (start) state_nxt = req_bad ? DONE : ISSUE;
      ISSUE: begin
        mem_rd    = tap_ok;
        state_nxt = CAPT;
      end
      CAPT:  state_nxt = (tap == 3'd4) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr = mem_rd ? tap_addr : addr_hold;
  assign err      = done & err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap       <= 3'd0;
      base_q    <= '0;
      addr_hold <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      cuarenta  <= '0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          row_q  <= fila;
          col_q  <= col;
          tap    <= 3'd0;
          err_q  <= req_bad;
          if (req_bad) cuarenta <= '0;
        end
        ISSUE: if (tap_ok) addr_hold <= tap_addr;
        CAPT: begin
          shadow[tap] <= cap_byte;
          // Publish only the complete word so downstream never sees a half-built window.
          if (tap == 3'd4) cuarenta <= {shadow[0], shadow[1], shadow[2], shadow[3], cap_byte};
          else             tap <= tap + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
